// File: rtl/sky_xu_pkg.sv
// Shared definitions for the sky_xu data-memory path.
//   rsp_owner_e : which port (if any) owns the response in flight
//   WORD_ADDR_W : width of the word index carried in a 32-bit byte address
//   mem_req_t   : one memory request (byte address, store flag, store data)
package sky_xu_pkg;

  localparam int unsigned WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_X    = 2'd1,
    OWN_D    = 2'd2
  } rsp_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sky_dmem_legal_check.sv
// Combinational legality check for a data-memory byte address.
//   addr    in  32 : byte address of the granted request
//   illegal out 1  : address is misaligned or beyond 4*MEM_WORDS bytes
import sky_xu_pkg::*;

module sky_dmem_legal_check #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic [31:0] addr,
  output logic        illegal
);

  logic [WORD_ADDR_W-1:0] word_idx;

  // Comparing word index against the depth is the same as comparing the
  // byte address against 4*MEM_WORDS, and avoids overflowing the limit.
  always_comb begin
    word_idx = addr[31:2];
    illegal  = (addr[1:0] != 2'b00) ||
               ({3'b000, word_idx} >= 33'(MEM_WORDS));
  end

endmodule

// File: rtl/sky_dmem_arbiter.sv
// Two-port arbiter in front of the single-ported sky_data_memory.
// Port X (XU memory stage) has fixed priority; port D (DMA/debug) wins one
// arbitration after STARVE_LIMIT consecutive lost cycles. Each accepted
// request gets exactly one response on the following cycle; illegal
// addresses are accepted but never reach the memory and return rsp_err.
//   clk, reset (async active-low)
//   x_req_* / d_req_* : request valid/ready/write/addr/wdata per port
//   x_rsp_* / d_rsp_* : response valid/rdata/err per port
//   x_stall           : X request present but not accepted
//   mem_*             : command to and registered read data from memory
import sky_xu_pkg::*;

module sky_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        x_req_valid,
  output logic        x_req_ready,
  input  logic        x_req_write,
  input  logic [31:0] x_req_addr,
  input  logic [31:0] x_req_wdata,
  output logic        x_rsp_valid,
  output logic [31:0] x_rsp_rdata,
  output logic        x_rsp_err,
  output logic        x_stall,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_write,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,

  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rsp_owner_e  rsp_owner, rsp_owner_next;
  logic        rsp_is_read, rsp_is_read_next;
  logic        rsp_err_q, rsp_err_next;
  logic [3:0]  starve_cnt, starve_cnt_next;

  logic        d_prio, gnt_x, gnt_d, req_illegal;
  logic [31:0] rsp_data;
  mem_req_t    gnt_req;

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    d_prio  = (starve_cnt == LIMIT) && d_req_valid;
    gnt_d   = reset && d_req_valid && (d_prio || !x_req_valid);
    gnt_x   = reset && x_req_valid && !d_prio;
    gnt_req = '0;
    if (gnt_d) begin
      gnt_req.addr  = d_req_addr;
      gnt_req.write = d_req_write;
      gnt_req.wdata = d_req_wdata;
    end else if (gnt_x) begin
      gnt_req.addr  = x_req_addr;
      gnt_req.write = x_req_write;
      gnt_req.wdata = x_req_wdata;
    end
  end

  sky_dmem_legal_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_legal_check (
    .addr    (gnt_req.addr),
    .illegal (req_illegal)
  );

  assign x_req_ready = gnt_x;
  assign d_req_ready = gnt_d;
  assign x_stall     = x_req_valid & ~x_req_ready;

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    if ((gnt_x || gnt_d) && !req_illegal) begin
      mem_address    = gnt_req.addr;
      mem_write_data = gnt_req.wdata;
      mem_write_en   = gnt_req.write;
      mem_read_en    = ~gnt_req.write;
    end
  end

  // Next response-tracking state and starvation count.
  always_comb begin
    rsp_owner_next   = OWN_NONE;
    rsp_is_read_next = ~gnt_req.write;
    rsp_err_next     = req_illegal && (gnt_x || gnt_d);
    starve_cnt_next  = starve_cnt;
    if (gnt_d) begin
      rsp_owner_next = OWN_D;
    end else if (gnt_x) begin
      rsp_owner_next = OWN_X;
    end
    if (!d_req_valid || gnt_d) begin
      starve_cnt_next = '0;
    end else if (gnt_x && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_owner   <= OWN_NONE;
      rsp_is_read <= 1'b0;
      rsp_err_q   <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      rsp_owner   <= rsp_owner_next;
      rsp_is_read <= rsp_is_read_next;
      rsp_err_q   <= rsp_err_next;
      starve_cnt  <= starve_cnt_next;
    end
  end

  always_comb begin
    rsp_data    = (rsp_is_read && !rsp_err_q) ? mem_read_data : '0;
    x_rsp_valid = (rsp_owner == OWN_X);
    d_rsp_valid = (rsp_owner == OWN_D);
    x_rsp_rdata = x_rsp_valid ? rsp_data : '0;
    d_rsp_rdata = d_rsp_valid ? rsp_data : '0;
    x_rsp_err   = x_rsp_valid && rsp_err_q;
    d_rsp_err   = d_rsp_valid && rsp_err_q;
  end

endmodule

// File: tb/tb_sky_dmem_arbiter.sv
module tb_sky_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_req_valid, x_req_ready, x_req_write;
  logic [31:0] x_req_addr, x_req_wdata;
  logic        x_rsp_valid, x_rsp_err, x_stall;
  logic [31:0] x_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_write;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_en;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  // Single-ported memory with registered read data.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[11:2]] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_address[11:2]];
  end

  sky_dmem_arbiter #(.STARVE_LIMIT(4), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .x_req_valid(x_req_valid), .x_req_ready(x_req_ready), .x_req_write(x_req_write),
    .x_req_addr(x_req_addr), .x_req_wdata(x_req_wdata), .x_rsp_valid(x_rsp_valid),
    .x_rsp_rdata(x_rsp_rdata), .x_rsp_err(x_rsp_err), .x_stall(x_stall),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
    .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic set_x(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    x_req_valid = v; x_req_write = w; x_req_addr = a; x_req_wdata = d;
  endtask

  task automatic set_d(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    d_req_valid = v; d_req_write = w; d_req_addr = a; d_req_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_read_data = 32'h0;
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    set_d(1'b1, 1'b1, 32'h20, 32'h1111_2222);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (x_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: x=%b d=%b required 0 0", x_req_ready, d_req_ready);
    end
    checks++;
    if ({mem_read_en, mem_write_en} !== 2'b00 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      failures++; $display("FAIL reset_mem: re=%b we=%b addr=%h wd=%h required all 0",
                           mem_read_en, mem_write_en, mem_address, mem_write_data);
    end
    checks++;
    if ({x_rsp_valid, d_rsp_valid, x_rsp_err, d_rsp_err} !== 4'b0 || x_rsp_rdata !== 32'h0 || d_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rsp: xv=%b dv=%b xe=%b de=%b xr=%h dr=%h required all 0",
                           x_rsp_valid, d_rsp_valid, x_rsp_err, d_rsp_err, x_rsp_rdata, d_rsp_rdata);
    end
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (x_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL post_reset_rsp[%0d]: xv=%b dv=%b required 0 0", i, x_rsp_valid, d_rsp_valid);
      end
    end
  endtask

  task automatic test_round_trip();
    @(negedge clk);
    set_x(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (x_req_ready !== 1'b1 || mem_write_en !== 1'b1 || mem_read_en !== 1'b0 ||
        mem_address !== 32'h10 || mem_write_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rt_store_cmd: rdy=%b we=%b re=%b addr=%h wd=%h required 1 1 0 00000010 deadbeef",
                           x_req_ready, mem_write_en, mem_read_en, mem_address, mem_write_data);
    end
    @(negedge clk);
    checks++;
    if (x_rsp_valid !== 1'b1 || x_rsp_err !== 1'b0 || x_rsp_rdata !== 32'h0 || d_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rt_store_rsp: v=%b err=%b rdata=%h dv=%b required 1 0 00000000 0",
                           x_rsp_valid, x_rsp_err, x_rsp_rdata, d_rsp_valid);
    end
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checks++;
    if (x_req_ready !== 1'b1 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_address !== 32'h10) begin
      failures++; $display("FAIL rt_load_cmd: rdy=%b re=%b we=%b addr=%h required 1 1 0 00000010",
                           x_req_ready, mem_read_en, mem_write_en, mem_address);
    end
    @(negedge clk);
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b1 || x_rsp_err !== 1'b0 || x_rsp_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rt_load_rsp: v=%b err=%b rdata=%h required 1 0 deadbeef",
                           x_rsp_valid, x_rsp_err, x_rsp_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rt_pulse: xv=%b dv=%b required 0 0", x_rsp_valid, d_rsp_valid);
    end
  endtask

  // X store, D load of the same word, X load: no bubbles between them.
  task automatic test_back_to_back();
    @(negedge clk);
    set_x(1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5);
    @(negedge clk);
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 32'h30, 32'h0);
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || x_rsp_valid !== 1'b1 || x_rsp_err !== 1'b0) begin
      failures++; $display("FAIL b2b_step1: drdy=%b xv=%b xerr=%b required 1 1 0", d_req_ready, x_rsp_valid, x_rsp_err);
    end
    @(negedge clk);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || x_rsp_valid !== 1'b0 || d_rsp_rdata !== 32'hA5A5_A5A5 || x_req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_step2: dv=%b xv=%b drdata=%h xrdy=%b required 1 0 a5a5a5a5 1",
                           d_rsp_valid, x_rsp_valid, d_rsp_rdata, x_req_ready);
    end
    @(negedge clk);
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0 || x_rsp_rdata !== 32'hDEAD_BEEF || d_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL b2b_step3: xv=%b dv=%b xrdata=%h drdata=%h required 1 0 deadbeef 00000000",
                           x_rsp_valid, d_rsp_valid, x_rsp_rdata, d_rsp_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_d, prev_d;
    prev_d = 1'b0;
    @(negedge clk);
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    set_d(1'b1, 1'b0, 32'h30, 32'h0);
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_d = ((i % 5) == 4);
      if (i > 0) begin
        checks++;
        if (x_rsp_valid !== !prev_d || d_rsp_valid !== prev_d ||
            (prev_d ? d_rsp_rdata : x_rsp_rdata) !== (prev_d ? 32'hA5A5_A5A5 : 32'hDEAD_BEEF)) begin
          failures++; $display("FAIL starve_rsp[%0d]: xv=%b dv=%b xr=%h dr=%h required d_owner=%b",
                               i, x_rsp_valid, d_rsp_valid, x_rsp_rdata, d_rsp_rdata, prev_d);
        end
      end
      checks++;
      if (x_req_ready !== !exp_d || d_req_ready !== exp_d || x_stall !== exp_d) begin
        failures++; $display("FAIL starve_grant[%0d]: xrdy=%b drdy=%b stall=%b required %b %b %b",
                             i, x_req_ready, d_req_ready, x_stall, !exp_d, exp_d, exp_d);
      end
      prev_d = exp_d;
      @(negedge clk);
      #1;
    end
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_x(1'b1, 1'b1, 32'h0, 32'h0BAD_F00D);
    @(negedge clk);
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b1, 1'b1, 32'hFFC, 32'h600D_CAFE);
    #1;
    checks++;
    if (mem_write_en !== 1'b1 || mem_address !== 32'hFFC) begin
      failures++; $display("FAIL ill_top_word_cmd: we=%b addr=%h required 1 00000ffc", mem_write_en, mem_address);
    end
    @(negedge clk);
    set_d(1'b1, 1'b0, 32'h2, 32'h0);
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
      failures++; $display("FAIL ill_misaligned_cmd: drdy=%b re=%b we=%b required 1 0 0", d_req_ready, mem_read_en, mem_write_en);
    end
    @(negedge clk);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    set_x(1'b1, 1'b1, 32'h1000, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL ill_misaligned_rsp: v=%b err=%b rdata=%h required 1 1 00000000", d_rsp_valid, d_rsp_err, d_rsp_rdata);
    end
    checks++;
    if (x_req_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_read_en !== 1'b0) begin
      failures++; $display("FAIL ill_range_cmd: xrdy=%b we=%b re=%b required 1 0 0", x_req_ready, mem_write_en, mem_read_en);
    end
    @(negedge clk);
    set_x(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b1 || x_rsp_err !== 1'b1 || x_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL ill_range_rsp: v=%b err=%b rdata=%h required 1 1 00000000", x_rsp_valid, x_rsp_err, x_rsp_rdata);
    end
    @(negedge clk);
    set_x(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (x_rsp_err !== 1'b1 || x_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL ill_high_addr_rsp: err=%b rdata=%h required 1 00000000", x_rsp_err, x_rsp_rdata);
    end
    @(negedge clk);
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 32'hFFC, 32'h0);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b1 || x_rsp_err !== 1'b0 || x_rsp_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL ill_mem_unchanged: v=%b err=%b rdata=%h required 1 0 0badf00d", x_rsp_valid, x_rsp_err, x_rsp_rdata);
    end
    @(negedge clk);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0 || d_rsp_rdata !== 32'h600D_CAFE) begin
      failures++; $display("FAIL ill_top_word_rsp: v=%b err=%b rdata=%h required 1 0 600dcafe", d_rsp_valid, d_rsp_err, d_rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_d;
    @(negedge clk);
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    set_d(1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (x_rsp_valid !== 1'b0 || x_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_reset_drop: xv=%b xr=%h required 0 00000000", x_rsp_valid, x_rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (x_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL mid_reset_no_rsp[%0d]: xv=%b dv=%b required 0 0", i, x_rsp_valid, d_rsp_valid);
      end
    end
    // A cleared starvation count shows up as four X grants before D.
    set_x(1'b1, 1'b0, 32'h10, 32'h0);
    set_d(1'b1, 1'b0, 32'h30, 32'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_d = (i == 4);
      checks++;
      if (x_req_ready !== !exp_d || d_req_ready !== exp_d) begin
        failures++; $display("FAIL mid_reset_cnt[%0d]: xrdy=%b drdy=%b required %b %b",
                             i, x_req_ready, d_req_ready, !exp_d, exp_d);
      end
      @(negedge clk);
      #1;
    end
    set_x(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_trip();
    test_back_to_back();
    test_starvation();
    test_illegal();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sky_dmem_arbiter.md
# sky_dmem_arbiter

Two-port arbiter that shares the single-ported `sky_data_memory` between the XU memory stage (port X) and a DMA/debug requester (port D). Port X has fixed priority, guarded by a starvation limit that guarantees port D forward progress. Each accepted request gets exactly one response one cycle later. Illegal addresses are trapped before they reach the memory. The block sits between `sky_memory_stage` and `sky_data_memory` inside `sky_xu`, and supplies the pipeline stall for port X.

## Interface
- `STARVE_LIMIT`, 4: consecutive lost cycles after which port D wins one arbitration; legal range 1..15.
- `MEM_WORDS`, 1024: backing memory depth in 32-bit words; byte address limit is `4*MEM_WORDS`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous assert, active-low; release is synchronous to `clk`.
- `x_req_valid` / `d_req_valid` in 1: request present.
- `x_req_ready` / `d_req_ready` out 1: request accepted this cycle.
- `x_req_write` / `d_req_write` in 1: 1 = store, 0 = load.
- `x_req_addr` / `d_req_addr` in 32: byte address.
- `x_req_wdata` / `d_req_wdata` in 32: store data.
- `x_rsp_valid` / `d_rsp_valid` out 1: response for the request accepted on the previous cycle.
- `x_rsp_rdata` / `d_rsp_rdata` out 32: load data; 0 for stores and errors.
- `x_rsp_err` / `d_rsp_err` out 1: the request was illegal and was not performed.
- `x_stall` out 1: `x_req_valid & ~x_req_ready`.
- `mem_address` out 32, `mem_read_en` out 1, `mem_write_en` out 1, `mem_write_data` out 32: memory command.
- `mem_read_data` in 32: registered memory read data.

## Operation
- **Grant rule (combinational, every cycle):**
  - If `starve_cnt == STARVE_LIMIT` and `d_req_valid`, grant D.
  - Otherwise grant X if `x_req_valid`, else D if `d_req_valid`, else no grant.
  - At most one `*_req_ready` is high in any cycle.
- **Legality check:** a request is illegal if `addr[1:0] != 0` or `addr >= 4*MEM_WORDS`.
  - An illegal granted request is accepted (ready=1) but drives `mem_read_en = mem_write_en = 0`.
  - It returns `rsp_err=1` with `rsp_rdata=0`.
- **Legal granted request:**
  - `mem_address = addr`, `mem_write_data = wdata`.
  - `mem_write_en = write`, `mem_read_en = ~write`.
- **No grant:** all `mem_*` outputs are 0.
- **Response tracking:** registers `rsp_owner` (none / X / D), `rsp_is_read` and `rsp_err_q` capture the grant at each edge.
  - The next cycle, exactly one `*_rsp_valid` is high.
  - `rsp_rdata = mem_read_data` only when `rsp_is_read & ~rsp_err_q`, else 0.
- **Starvation counter `starve_cnt`:**
  - Increments when `d_req_valid` and X is granted.
  - Clears when D is granted or `d_req_valid` is 0.
  - Saturates at `STARVE_LIMIT`.
- A D-priority grant while `x_req_valid` holds X stalled for exactly that one cycle.

## Timing
- **Reset values (while `reset` low):**
  - `rsp_owner` = none, `starve_cnt` = 0.
  - All `*_rsp_valid`, `*_rsp_err` and `*_rsp_rdata` are 0.
  - All `*_req_ready` are forced 0; all `mem_*` outputs are 0.
- **Reset mid-operation:** a response pending when `reset` asserts is dropped and no `rsp_valid` appears after release. The first grant is possible in the first cycle with `reset` high.
- **Latency:** request to response is exactly 1 cycle. Throughput is 1 request per cycle, back-to-back with no bubble, including X→D→X alternation.
- **Handshake:**
  - `req_ready` depends combinationally on both valids and `starve_cnt`.
  - Requesters hold `addr`/`write`/`wdata` stable while `valid & ~ready`.
  - `rsp_valid` is a one-cycle pulse with no backpressure.
- **Store then load to the same address on consecutive cycles:** the load returns the new data, because the memory writes at edge N and reads at edge N+1.

## Structure
- The shared package `sky_xu_pkg` holds:
  - the `rsp_owner_e` enum (`OWN_NONE`, `OWN_X`, `OWN_D`);
  - the word-address width constant;
  - the memory request struct (`addr`, `write`, `wdata`).
- Sub-module `sky_dmem_legal_check` (combinational, parameter `MEM_WORDS`): maps addr → illegal flag. It is instantiated once, on the granted request.
- `sky_xu` replaces its direct memory-stage→memory connection with this block. `pipeline_stall` is driven from `x_stall`.

## Test plan
- **Reset:** `reset` low with both valids high → both ready 0, all `mem_*` 0, no rsp for 3 cycles after release.
- **Round trip:** X stores 0xDEADBEEF @0x10, next cycle X loads @0x10 → `x_rsp_rdata` = 0xDEADBEEF one cycle after the load's accept, `x_rsp_err` = 0.
- **Starvation:** with `STARVE_LIMIT`=4, X and D both valid continuously → grant pattern X,X,X,X,D repeating. `x_stall` is high only on the D cycles.
- **Illegal addresses:**
  - D loads @0x2 → `d_rsp_err` = 1, `d_rsp_rdata` = 0, `mem_read_en` stays 0.
  - X stores @0x1000 (MEM_WORDS=1024) → `x_rsp_err` = 1, memory is unchanged.
- **Reset mid-request:** assert `reset` in the cycle after an X load is accepted → no `x_rsp_valid` ever appears for that load, and `starve_cnt` reads 0 after release.
